// File: rtl/hcode_fifo_pack_32to128_pkg.sv
// rtl/hcode_fifo_pack_32to128_pkg.sv - shared defaults, state enum and lane mask for the 32-to-128 packer
// Purpose: width defaults, FSM state type and the helper that turns a held-lane
//          count into a per-lane keep mask (lanes at or above the count are zeroed).
// Ports:   none (package).
package hcode_fifo_pkg;

  localparam int DEF_IN_W   = 32;
  localparam int DEF_RATIO  = 4;
  localparam int DEF_OUT_W  = DEF_IN_W * DEF_RATIO;
  localparam int DEF_CNT_W  = 32;
  localparam int LANE_W     = $clog2(DEF_RATIO);

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Bit i set means lane i holds a real word and is kept in a flushed beat.
  function automatic logic [DEF_RATIO-1:0] lane_mask(input logic [LANE_W-1:0] lanes);
    logic [DEF_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < DEF_RATIO; i++) begin
      if (i < int'(lanes)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hcode_fifo_pack_32to128_if.sv
// rtl/hcode_fifo_pack_32to128_if.sv - host-side and subshell-side FIFO signals of the packer
// Purpose: bundles the host FWFT read port, the flush pulse and the subshell write port.
// Ports:   in_dout/in_empty_n/in_read (host FIFO), flush, out_din/out_full/out_write (subshell FIFO).
//          slave = packer view, master = environment view.
interface hcode_fifo_pack_32to128_if
  import hcode_fifo_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO
);
  logic [IN_W-1:0]       in_dout;
  logic                  in_empty_n;
  logic                  in_read;
  logic                  flush;
  logic [IN_W*RATIO-1:0] out_din;
  logic                  out_full;
  logic                  out_write;

  modport slave (
    input  in_dout, in_empty_n, flush, out_full,
    output in_read, out_din, out_write
  );

  modport master (
    output in_dout, in_empty_n, flush, out_full,
    input  in_read, out_din, out_write
  );
endinterface

// File: rtl/hcode_fifo_pack_32to128_hold.sv
// rtl/hcode_fifo_pack_32to128_hold.sv - single-entry output holding register with load/drain handshake
// Purpose: holds one packed beat until the subshell FIFO accepts it.
// Ports:   ap_clk, ap_rst; i_load/i_data (new beat, only when o_free); i_full (downstream full);
//          o_din (held beat), o_pend (beat valid), o_write (beat accepted this cycle),
//          o_free (register can take a new beat this cycle).
module hcode_out_hold #(
  parameter int OUT_W = 128
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_data,
  input  logic             i_full,
  output logic [OUT_W-1:0] o_din,
  output logic             o_pend,
  output logic             o_write,
  output logic             o_free
);
  logic [OUT_W-1:0] r_hold;
  logic             r_pend;
  logic             w_drain;

  assign w_drain = r_pend & ~i_full;
  // The register frees up in the same cycle it drains, so a new beat can
  // load back-to-back without a bubble.
  assign o_free  = ~r_pend | w_drain;
  assign o_write = w_drain & ~ap_rst;
  assign o_pend  = r_pend;
  assign o_din   = r_hold;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_hold <= '0;
      r_pend <= 1'b0;
    end else if (i_load) begin
      r_hold <= i_data;
      r_pend <= 1'b1;
    end else if (w_drain) begin
      r_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/hcode_fifo_pack_32to128.sv
// rtl/hcode_fifo_pack_32to128.sv - packs four 32-bit host words into one 128-bit subshell beat
// Purpose: accumulator, lane counter, ACCUM/FLUSH state machine and status counters.
// Ports:   ap_clk, ap_rst; fifo (slave modport: host read port, flush, subshell write port);
//          lanes_held (words in accumulator), beat_cnt (beats written), word_cnt (words popped).
module hcode_fifo_pack_32to128
  import hcode_fifo_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  hcode_fifo_pack_32to128_if.slave         fifo,
  output logic [LANE_W-1:0]                lanes_held,
  output logic [CNT_W-1:0]                 beat_cnt,
  output logic [CNT_W-1:0]                 word_cnt
);
  localparam int                ACC_W = IN_W * (RATIO - 1);
  localparam int                OUT_W = IN_W * RATIO;
  localparam logic [LANE_W-1:0] LAST  = LANE_W'(RATIO - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [LANE_W-1:0]   r_lanes;
  logic [LANE_W-1:0]   w_lanes_post;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                w_read;
  logic                w_load;
  logic [OUT_W-1:0]    w_load_data;
  logic                w_free;
  logic                w_write;
  logic [RATIO-1:0]    w_lane_en;
  logic [ACC_W-1:0]    w_acc_mask;

  assign w_lane_en = lane_mask(r_lanes);

  for (genvar g = 0; g < RATIO - 1; g++) begin : g_mask
    assign w_acc_mask[g*IN_W +: IN_W] = {IN_W{w_lane_en[g]}};
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_read       = 1'b0;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_lanes_post = r_lanes;
    unique case (r_state)
      ACCUM: begin
        // A full accumulator can only pop if the output register can take the beat.
        w_read      = fifo.in_empty_n & ((r_lanes != LAST) | w_free);
        w_load_data = {fifo.in_dout, r_acc};
        if (w_read) begin
          if (r_lanes == LAST) begin
            w_load       = 1'b1;
            w_lanes_post = '0;
          end else begin
            w_lanes_post = r_lanes + 1'b1;
          end
        end
        // Flush judged on the post-pop count: a 4th-word pop already emits the beat.
        if (fifo.flush && (w_lanes_post != '0)) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_load_data = {{IN_W{1'b0}}, r_acc & w_acc_mask};
        if (w_free) begin
          w_load       = 1'b1;
          w_lanes_post = '0;
          w_state_nxt  = ACCUM;
        end
      end
      default: ;
    endcase
    if (ap_rst) begin
      w_read = 1'b0;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= ACCUM;
      r_lanes    <= '0;
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lanes <= w_lanes_post;
      if (w_read && (r_lanes != LAST)) r_acc[r_lanes*IN_W +: IN_W] <= fifo.in_dout;
      if (w_write) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_read)  r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  hcode_out_hold #(.OUT_W(OUT_W)) u_hold (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_full  (fifo.out_full),
    .o_din   (fifo.out_din),
    .o_pend  (),
    .o_write (w_write),
    .o_free  (w_free)
  );

  assign fifo.in_read   = w_read;
  assign fifo.out_write = w_write;
  assign lanes_held     = r_lanes;
  assign beat_cnt       = r_beat_cnt;
  assign word_cnt       = r_word_cnt;
endmodule

// File: doc/hcode_fifo_pack_32to128.md
# hcode_fifo_pack_32to128

Upstream width-adapter stage feeding a subshell's 128-bit ap_fifo input port. Drains 32-bit words from a host-side FWFT FIFO, packs four consecutive words into one 128-bit beat, and writes the beat into the subshell input FIFO, which exposes a write/full interface. A flush request emits a zero-padded partial beat. Sustains one 32-bit word per cycle when not backpressured.

## Interface
Parameters:
- IN_W, 32, host word width
- RATIO, 4, words per output beat; OUT_W = IN_W*RATIO = 128
- CNT_W, 32, width of status counters

Ports:
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_dout  in  IN_W  host FIFO head word (first-word-fall-through)
- in_empty_n  in  1  host FIFO holds a word
- in_read  out  1  pop host word this cycle
- flush  in  1  single-cycle pulse: emit pending partial beat
- out_din  out  OUT_W  packed beat to subshell input FIFO
- out_full  in  1  subshell input FIFO full
- out_write  out  1  push out_din this cycle
- lanes_held  out  2  words currently in accumulator (0..3)
- beat_cnt  out  CNT_W  beats accepted downstream, wraps at 2^CNT_W
- word_cnt  out  CNT_W  host words popped, wraps at 2^CNT_W

## Operation
- Packing is little-endian: the first word popped occupies out_din[31:0], the fourth occupies [127:96].
- Single-entry output holding register `hold`/`pend`. out_write = pend & ~out_full (combinational); the beat is accepted on any cycle in which out_write=1.
- `drain` = pend & ~out_full. Output register is free when ~pend | drain.
- States: ACCUM, FLUSH.
- ACCUM: in_read = in_empty_n & (lanes_held!=3 | ~pend | ~out_full).
  - Pop with lanes_held<3: the word is written into lane lanes_held, and lanes_held increments.
  - Pop with lanes_held==3: {in_dout, acc[95:0]} loads into `hold`, pend is set, and lanes_held returns to 0.
  - flush=1 with the post-pop lanes_held>0: the state goes to FLUSH. Otherwise flush is ignored. A word popped in the flush cycle is counted before the flush takes effect.
- FLUSH: in_read=0. When the output register is free, `hold` loads acc with lanes ≥ lanes_held zeroed, pend is set, lanes_held returns to 0, and the state returns to ACCUM.
- Accumulator lanes above lanes_held are don't-care internally, but they always appear as zeros on out_din for flushed beats.
- beat_cnt increments on out_write. word_cnt increments on in_read.
- Reset values: in_read=0, out_write=0, out_din=0, lanes_held=0, beat_cnt=0, word_cnt=0, state ACCUM, pend=0.
- Reset mid-operation discards any partial or pending beat. Nothing is written on the cycle after reset.

## Timing
- The fourth word popped at cycle N makes out_write=1 in cycle N+1 when out_full=0.
- Pop-to-write latency is 1 cycle, with no combinational path from in_dout to out_din.
- Steady state with no backpressure: one beat every 4 cycles, and in_read held high continuously.
- The host is popped on the same cycle that a completed beat drains, so no bubble is inserted.
- out_full held high: at most 3 words are accumulated plus 1 beat pending. After that, in_read=0.
- in_read depends combinationally on out_full.
- flush pulsed in ACCUM with lanes_held=k>0 and the output register free: the padded beat is written 2 cycles after the flush (FLUSH entered at N+1, out_write at N+2).
- flush while already in FLUSH is ignored.
- in_empty_n=0 never asserts in_read. out_write never asserts while pend=0.

## Structure
- Shared package hcode_fifo_pkg holds the IN_W/OUT_W/RATIO defaults, the state enum {ACCUM, FLUSH}, and a lane-mask function (lanes_held → zero mask).
- One sub-module: hcode_out_hold, a single-entry output register with a load/drain handshake that produces pend, out_din and out_write.
- The top module contains the accumulator, lane counter, state machine and status counters.

## Test plan
- Streaming: push words 0x1..0x8, out_full=0 → beats 0x00000004_00000003_00000002_00000001 and 0x8_7_6_5 (same 32-bit lane packing), beat_cnt=2, word_cnt=8, in_read high for 8 consecutive cycles.
- Backpressure: out_full=1 with 12 words available → exactly 7 pops, then in_read=0. Release out_full → all 3 beats arrive in order, with no loss or duplication.
- Flush partial: push 0xA, 0xB, then flush → one beat 0x00000000_00000000_0000000B_0000000A, lanes_held=0.
- Flush coincident with the 4th pop: words 1..4 with flush on the 4th pop cycle → a single full beat 4_3_2_1, and no extra zero beat.
- Flush when empty: flush with lanes_held=0 → no write, state stays ACCUM.
- Reset mid-beat: 2 words held plus a pending beat under out_full=1, then ap_rst for 1 cycle → all outputs 0, counters 0. The next 4 words form a clean beat.
